wshb_arbiter: RTL

//  Two-master, one-slave Wishbone arbiter in front of the SDRAM controller.

---
 rtl/wshb_if.sv | 29 ++
 rtl/wshb_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/wshb_if.sv
// Wishbone B4 classic/registered-burst bus bundle.
// Carries request, write data, ack and read data for one master/slave link.
interface wshb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_ms;
  logic [DW/8-1:0] sel;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic [DW-1:0] dat_sm;

  modport master (
    output cyc, stb, we, adr, dat_ms,
    output sel, cti, bte,
    input  ack, dat_sm
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms,
    input  sel, cti, bte,
    output ack, dat_sm
  );
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller.
// Ports: clk, rst (sync, active-high); m0/m1 master links (slave
// modport), s slave link (master modport), gnt one-hot grant {m1,m0}.
// Round-robin per cyc, one idle cycle between grants, and a hold
// limit of MAX_HOLD acks while the other master is waiting.
module wshb_arbiter #(
  parameter int MAX_HOLD = 64,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic       clk,
  input  logic       rst,
  wshb_if.slave      m0,
  wshb_if.slave      m1,
  wshb_if.master     s,
  output logic [1:0] gnt
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          last_q;
  logic [HW-1:0] hold_q;
  logic          other_cyc;
  logic          hold_max;
  logic          preempt;

  assign gnt = {state_q == G1, state_q == G0};

  // Cycle of the master not currently holding the bus.
  assign other_cyc = gnt[0] ? m1.cyc : m0.cyc;
  assign hold_max  = (hold_q == HOLD_MAX);
  // Only after an ack, so no strobe is abandoned mid-transfer.
  assign preempt   = s.ack & other_cyc & hold_max;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0.cyc && m1.cyc)
          state_d = last_q ? G0 : G1;
        else if (m0.cyc)
          state_d = G0;
        else if (m1.cyc)
          state_d = G1;
      end
      G0: if (!m0.cyc || preempt) state_d = IDLE;
      G1: if (!m1.cyc || preempt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        hold_q <= '0;
        if (state_d == G0) last_q <= 1'b0;
        if (state_d == G1) last_q <= 1'b1;
      end else if (s.ack && other_cyc && !hold_max) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  // Idle bus parks on m0 for the qualifier fields; cyc/stb stay low.
  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = m0.we;
    s.adr    = m0.adr;
    s.dat_ms = m0.dat_ms;
    s.sel    = m0.sel;
    s.cti    = m0.cti;
    s.bte    = m0.bte;
    unique case (1'b1)
      gnt[0]: begin
        s.cyc = m0.cyc;
        s.stb = m0.stb;
      end
      gnt[1]: begin
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.we     = m1.we;
        s.adr    = m1.adr;
        s.dat_ms = m1.dat_ms;
        s.sel    = m1.sel;
        s.cti    = m1.cti;
        s.bte    = m1.bte;
      end
      default: ;
    endcase
  end

  assign m0.ack    = s.ack & gnt[0];
  assign m1.ack    = s.ack & gnt[1];
  assign m0.dat_sm = s.dat_sm;
  assign m1.dat_sm = s.dat_sm;

endmodule
